// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, reused by the RX, TX and baud generator.
package uart_pkg;

  localparam int NB_DATA_DEF    = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to all ones (idle line level).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// Oversampled UART receiver that pushes each good frame into the RX FIFO with a one-cycle strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  input  logic               i_fifo_full,
  output logic               o_write_fifo,
  output logic [NB_DATA-1:0] o_data_to_write,
  output logic               o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output logic               o_overrun_err
);

  localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic               rx_s;
`ifdef UART_RX_PARITY_EN
  logic               parity_bit;
`endif

  sync_2ff #(.WIDTH(1)) u_rx_sync (
    .clk   (i_clk),
    .rst_n (i_reset),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      o_write_fifo    <= 1'b0;
      o_data_to_write <= '0;
      o_frame_err     <= 1'b0;
      o_overrun_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit      <= 1'b0;
      o_parity_err    <= 1'b0;
`endif
    end else begin
      o_write_fifo  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        // A start bit that is no longer low at its midpoint is treated as a glitch.
        START: begin
          if (i_tick) begin
            if (tick_cnt == HALF_LAST) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              shreg    <= {rx_s, shreg[NB_DATA-1:1]};
              tick_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              parity_bit <= rx_s;
              tick_cnt   <= '0;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif
        // Frame error outranks parity error, which in turn suppresses overrun.
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                o_frame_err <= 1'b1;
                state       <= BREAK;
`ifdef UART_RX_PARITY_EN
              end else if ((^shreg) ^ parity_bit) begin
                o_parity_err <= 1'b1;
                state        <= IDLE;
`endif
              end else if (i_fifo_full) begin
                o_overrun_err <= 1'b1;
                state         <= IDLE;
              end else begin
                o_write_fifo    <= 1'b1;
                o_data_to_write <= shreg;
                state           <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed self-checking bench for uart_rx_fifo_feeder; ticks every 4 clocks, 16 ticks per bit.
module tb_uart_rx_fifo_feeder;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_fifo_full = 1'b0;
  logic       o_write_fifo;
  logic [7:0] o_data_to_write;
  logic       o_frame_err;
  logic       o_overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int compared = 0;
  int mismatched = 0;

  int n_write = 0;
  int n_frame = 0;
  int n_overrun = 0;
  int n_parity = 0;
  int bad_latency = 0;
  int multi_hot = 0;
  logic [7:0] wq[$];
  logic prev_tick = 1'b0;
  int tick_div = 0;

  uart_rx_fifo_feeder #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_tick          (i_tick),
    .i_rx            (i_rx),
    .i_fifo_full     (i_fifo_full),
    .o_write_fifo    (o_write_fifo),
    .o_data_to_write (o_data_to_write),
    .o_frame_err     (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err    (o_parity_err),
`endif
    .o_overrun_err   (o_overrun_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      tick_div = (tick_div + 1) % 4;
      i_tick = (tick_div == 0);
    end
  end

  // Pulse recorder: strobes must land in the cycle right after a tick cycle.
  always @(negedge i_clk) begin
    if (o_write_fifo === 1'b1) begin
      wq.push_back(o_data_to_write);
      n_write++;
      if (prev_tick !== 1'b1) bad_latency++;
    end
    if (o_frame_err === 1'b1) n_frame++;
    if (o_overrun_err === 1'b1) n_overrun++;
`ifdef UART_RX_PARITY_EN
    if (o_parity_err === 1'b1) n_parity++;
`endif
    if ((32'(o_write_fifo) + 32'(o_frame_err) + 32'(o_overrun_err)) > 1) multi_hot++;
    prev_tick = i_tick;
  end

  task automatic clear_mon();
    wq.delete();
    n_write = 0;
    n_frame = 0;
    n_overrun = 0;
    n_parity = 0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge i_clk); while (i_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic bad_par);
    i_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = (^data) ^ bad_par;
    wait_ticks(16);
`endif
    i_rx = stop_val;
    wait_ticks(16);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic test_reset();
    logic [7:0] first;
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    compared++; if (o_write_fifo !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_write got %b want 0", o_write_fifo); end
    compared++; if (o_data_to_write !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data got %h want 00", o_data_to_write); end
    compared++; if (o_frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame got %b want 0", o_frame_err); end
    compared++; if (o_overrun_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun got %b want 0", o_overrun_err); end
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    idle(8);
    first = 8'h00;
    clear_mon();
    compared++; if (n_write !== 0) begin mismatched++; $display("[TB] FAIL reset_idle_writes got %0d want 0 (first %h)", n_write, first); end
  endtask

  task automatic test_good_frame();
    logic [7:0] got;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    got = (wq.size() > 0) ? wq[0] : 8'hxx;
    compared++; if (n_write !== 1) begin mismatched++; $display("[TB] FAIL good_count got %0d want 1", n_write); end
    compared++; if (got !== 8'hA5) begin mismatched++; $display("[TB] FAIL good_data got %h want a5", got); end
    compared++; if (o_data_to_write !== 8'hA5) begin mismatched++; $display("[TB] FAIL good_hold got %h want a5", o_data_to_write); end
    compared++; if ((n_frame + n_overrun + n_parity) !== 0) begin mismatched++; $display("[TB] FAIL good_errs got %0d want 0", n_frame + n_overrun + n_parity); end
  endtask

  task automatic test_glitch();
    logic [7:0] got;
    clear_mon();
    i_rx = 1'b0;
    wait_ticks(4);
    idle(30);
    compared++; if ((n_write + n_frame + n_overrun) !== 0) begin mismatched++; $display("[TB] FAIL glitch_pulses got %0d want 0", n_write + n_frame + n_overrun); end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    got = (wq.size() > 0) ? wq[0] : 8'hxx;
    compared++; if (n_write !== 1) begin mismatched++; $display("[TB] FAIL glitch_next_count got %0d want 1", n_write); end
    compared++; if (got !== 8'h3C) begin mismatched++; $display("[TB] FAIL glitch_next_data got %h want 3c", got); end
  endtask

  task automatic test_frame_error();
    logic [7:0] got;
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(40);
    idle(20);
    compared++; if (n_frame !== 1) begin mismatched++; $display("[TB] FAIL frame_err_count got %0d want 1", n_frame); end
    compared++; if (n_write !== 0) begin mismatched++; $display("[TB] FAIL frame_err_write got %0d want 0", n_write); end
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(20);
    got = (wq.size() > 0) ? wq[0] : 8'hxx;
    compared++; if (n_write !== 1) begin mismatched++; $display("[TB] FAIL frame_next_count got %0d want 1", n_write); end
    compared++; if (got !== 8'h0F) begin mismatched++; $display("[TB] FAIL frame_next_data got %h want 0f", got); end
    compared++; if (n_frame !== 1) begin mismatched++; $display("[TB] FAIL frame_retrigger got %0d want 1", n_frame); end
  endtask

  task automatic test_overrun();
    clear_mon();
    i_fifo_full = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    i_fifo_full = 1'b0;
    compared++; if (n_overrun !== 1) begin mismatched++; $display("[TB] FAIL overrun_count got %0d want 1", n_overrun); end
    compared++; if (n_write !== 0) begin mismatched++; $display("[TB] FAIL overrun_write got %0d want 0", n_write); end
    compared++; if (o_data_to_write !== 8'h0F) begin mismatched++; $display("[TB] FAIL overrun_hold got %h want 0f", o_data_to_write); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    i_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      i_rx = i[0];
      wait_ticks(16);
    end
    i_reset = 1'b0;
    i_rx = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    compared++; if ({o_write_fifo, o_frame_err, o_overrun_err} !== 3'b000) begin mismatched++; $display("[TB] FAIL midreset_flags got %b want 000", {o_write_fifo, o_frame_err, o_overrun_err}); end
    compared++; if (o_data_to_write !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_data got %h want 00", o_data_to_write); end
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    clear_mon();
    idle(20);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    got = (wq.size() > 0) ? wq[0] : 8'hxx;
    compared++; if (n_write !== 1) begin mismatched++; $display("[TB] FAIL midreset_count got %0d want 1", n_write); end
    compared++; if (got !== 8'hFF) begin mismatched++; $display("[TB] FAIL midreset_word got %h want ff", got); end
    compared++; if ((n_frame + n_overrun) !== 0) begin mismatched++; $display("[TB] FAIL midreset_errs got %0d want 0", n_frame + n_overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[3];
    logic [7:0] got;
    exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'h7E;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b1, 1'b0);
    idle(20);
    compared++; if (n_write !== 3) begin mismatched++; $display("[TB] FAIL b2b_count got %0d want 3", n_write); end
    for (int i = 0; i < 3; i++) begin
      got = (wq.size() > i) ? wq[i] : 8'hxx;
      compared++; if (got !== exp_q[i]) begin mismatched++; $display("[TB] FAIL b2b_word%0d got %h want %h", i, got, exp_q[i]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    i_fifo_full = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    i_fifo_full = 1'b0;
    compared++; if (n_parity !== 1) begin mismatched++; $display("[TB] FAIL parity_count got %0d want 1", n_parity); end
    compared++; if ((n_write + n_overrun) !== 0) begin mismatched++; $display("[TB] FAIL parity_suppress got %0d want 0", n_write + n_overrun); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    compared++; if (bad_latency !== 0) begin mismatched++; $display("[TB] FAIL strobe_latency got %0d late want 0", bad_latency); end
    compared++; if (multi_hot !== 0) begin mismatched++; $display("[TB] FAIL exclusive_pulses got %0d want 0", multi_hot); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
- Oversampled UART receiver that deserialises the RX line into NB_DATA-bit words.
- Pushes each good frame into the RX FIFO through a single-cycle write strobe.
- Sits directly upstream of the fifo block:
  - o_write_fifo drives the FIFO's i_write_fifo.
  - o_data_to_write drives the FIFO's i_data_to_write.
  - The FIFO's full flag (o_fifo_is_full) returns as i_fifo_full.
- Baud timing comes from an external tick generator.

Parameters:
- NB_DATA, 8, data bits per frame (LSB first).
- OVERSAMPLE, 16, i_tick pulses per bit period.
- SB_TICK, 16, ticks sampled for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk, in, 1, system clock; all logic on rising edge.
- i_reset, in, 1, synchronous active-low reset; 0 = reset.
- i_tick, in, 1, one-cycle oversample enable at OVERSAMPLE x baud.
- i_rx, in, 1, asynchronous serial line; idles high.
- i_fifo_full, in, 1, downstream FIFO full flag.
- o_write_fifo, out, 1, one-cycle write strobe to the FIFO.
- o_data_to_write, out, NB_DATA, received word; stable from the strobe until the next strobe.
- o_frame_err, out, 1, one-cycle pulse: stop bit sampled low.
- o_overrun_err, out, 1, one-cycle pulse: good frame dropped because the FIFO was full.
- o_parity_err, out, 1, present only with UART_RX_PARITY_EN.

Behaviour:
- Reset (i_reset==0 at a clock edge), whether idle or mid-frame:
  - State = IDLE; tick and bit counters = 0; shift register = 0.
  - Synchroniser flops = 1.
  - All outputs = 0, including o_data_to_write.
  - A partial frame in progress is discarded.
- Input synchroniser: i_rx passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- Counters only advance on cycles with i_tick==1. The tick counter width is clog2(max(OVERSAMPLE, SB_TICK)).
- IDLE:
  - rx_s==0 -> START, tick_cnt=0.
- START:
  - On a tick with tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0.
    - rx_s==1 -> glitch; back to IDLE with no output.
  - Otherwise tick_cnt++.
- DATA:
  - On a tick with tick_cnt==OVERSAMPLE-1:
    - Shift right: shreg = {rx_s, shreg[NB_DATA-1:1]}; tick_cnt=0.
    - If bit_cnt==NB_DATA-1 -> STOP (or PARITY if enabled); else bit_cnt++.
- STOP:
  - On a tick with tick_cnt==SB_TICK-1, outcome depends on rx_s and i_fifo_full:
    - rx_s==1 and i_fifo_full==0 -> next cycle o_write_fifo=1 and o_data_to_write=shreg; go to IDLE.
    - rx_s==1 and i_fifo_full==1 -> next cycle o_overrun_err=1, no write; o_data_to_write unchanged; go to IDLE.
    - rx_s==0 -> next cycle o_frame_err=1, no write; go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering continuously.
- Latency: the strobe is registered and appears exactly one i_clk after the stop-decision tick cycle. The strobe is never held for more than one cycle.
- i_fifo_full is sampled only in the stop-decision cycle.
- At most one of o_write_fifo / o_frame_err / o_overrun_err is high in any cycle.
- A tick arriving in the same cycle as reset is ignored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one bit at tick_cnt==OVERSAMPLE-1.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - Mismatch -> o_parity_err pulses in the same cycle the frame completes, the word is not written, and o_overrun_err is suppressed.
  - A frame error takes precedence over a parity error.
- Undefined: no PARITY state, no o_parity_err port, and the frame is exactly start + NB_DATA + stop.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default NB_DATA, OVERSAMPLE, SB_TICK.
  - The same constants are reused by the UART TX and the baud generator.
- One natural sub-module: sync_2ff, a parameterisable-width 2-flop synchroniser with reset value 1, instantiated for i_rx.

Test Plan:
- Good frame:
  - Stimulus: send 0xA5 at OVERSAMPLE=16, i_fifo_full=0.
  - Response: one o_write_fifo pulse with o_data_to_write=0xA5, one cycle after the stop-decision tick; no error pulses.
- Glitch rejection:
  - Stimulus: drive i_rx low for 4 ticks, then high.
  - Response: return to IDLE with no strobe and no error; a following 0x3C frame is received correctly.
- Frame error:
  - Stimulus: send 0x55 with the stop bit forced low, then hold low 40 ticks, then high.
  - Response: a single o_frame_err pulse, no write, no retrigger during the low hold; a following 0x0F frame is received.
- Overrun:
  - Stimulus: send 0x81 with i_fifo_full=1.
  - Response: o_overrun_err pulse, no o_write_fifo, o_data_to_write keeps the previous word.
- Reset mid-frame:
  - Stimulus: pull i_reset to 0 after 3 data bits, release, then send 0xFF.
  - Response: all outputs 0 during reset; exactly one write of 0xFF afterwards.
- Back-to-back (with UART_RX_PARITY_EN: 0x07 with a wrong parity bit):
  - Stimulus: 0x00, 0xFF, 0x7E sent with no idle gap.
  - Response: three writes in order 0x00, 0xFF, 0x7E.
  - Parity case: o_parity_err pulse and no write.
